somador_serial: RTL and testbench
=================================

SOMADOR_SERIAL -- requirements
Module: somador_serial

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range WIDTH >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk edge.
REQ-005 a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-006 b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-007 cin  input  1  carry-in; sampled only when start is accepted.
REQ-008 busy  output  1  high while the serial computation is in progress.
REQ-009 done  output  1  one-cycle pulse when a new result is available.
REQ-010 sum  output  WIDTH  registered result, A+B+cin mod 2^WIDTH.
REQ-011 cout  output  1  registered carry out of the MSB.
REQ-012 ovf  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1, next edge: load A/B shift registers, carry FF <= cin, bit counter <= 0, go to SHIFT.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE with all registers unchanged.
REQ-016 Each SHIFT cycle: one full-adder cell adds A[0], B[0] and carry FF; sum bit shifts into the partial-sum register from the MSB end; carry FF <= cell carry; A and B shift right by one; counter increments.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; on the edge ending the last one: sum, cout and ovf registers load, go to DONE.
REQ-018 ovf SHALL use the carry FF value entering the MSB cycle and the cell carry out of the MSB cycle.
REQ-019 DONE SHALL last one cycle, then go to IDLE unconditionally.
REQ-020 Latency: start accepted at edge k -> busy=1 for cycles k+1..k+WIDTH -> done=1 in cycle k+WIDTH+1 only.
REQ-021 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE.
REQ-022 start in SHIFT or DONE SHALL be ignored; a, b and cin changes outside acceptance SHALL have no effect.
REQ-023 sum, cout and ovf SHALL hold the previous result during a new computation and change only at the REQ-017 edge.
REQ-024 Bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL not wrap within an operation.

Reset
REQ-025 rst=1 SHALL immediately force IDLE and clear all registers; busy, done, sum, cout and ovf all read 0.
REQ-026 rst asserted mid-SHIFT SHALL discard the operation with no done pulse; the first start after rst deassertion SHALL be accepted normally.

Configuration
REQ-027 With SOMADOR_SERIAL_SUB_EN defined, add input port sub (1 bit, sampled with start); sub=1 loads ~b into B and forces carry FF to 1 (cin ignored), giving A-B; sub=0 is identical to the default behaviour.
REQ-028 Without SOMADOR_SERIAL_SUB_EN, the sub port and its logic SHALL be absent; behaviour per REQ-013..REQ-026.

Structure
REQ-029 Shared package somador_pkg SHALL hold the FSM state encodings (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-030 The per-bit addition SHALL be a sub-module celula_soma (inputs a, b, cin; outputs s, cout; purely combinational, gate-level XOR/AND/OR), instanced once.

Verification
REQ-031 WIDTH=8, a=0x0F, b=0x01, cin=0, start at edge k -> busy cycles k+1..k+8; done only in cycle k+9; sum=0x10, cout=0, ovf=0.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-033 a=0x10, b=0x20, cin=1, start; start re-pulsed at SHIFT cycle 3 with a=0xFF -> single done; sum=0x31; no second operation starts.
REQ-034 Previous result 0x31; new start a=0x01, b=0x01; rst asserted at SHIFT cycle 4 -> all outputs 0 immediately, no done; new start a=0x02, b=0x03 -> sum=0x05.
REQ-035 SOMADOR_SERIAL_SUB_EN defined: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0; a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.

Source files
------------

// File: rtl/somador_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and the default width.
package somador_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/celula_soma.sv
// One-bit full-adder cell, gate-level, purely combinational.
module celula_soma (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic axb;

    assign axb  = a ^ b;
    assign s    = axb ^ cin;
    assign cout = (a & b) | (cin & axb);

endmodule

// File: rtl/somador_serial.sv
// Bit-serial adder: one full-adder cell processes one bit per cycle, LSB first.
// Optional macro SOMADOR_SERIAL_SUB_EN adds a 'sub' input that turns the operation into A-B.
module somador_serial
    import somador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SOMADOR_SERIAL_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   reg_a, reg_b, psum;
    logic [WIDTH-1:0]   sum_r;
    logic               carry, cout_r, ovf_r;
    logic [CNT_W-1:0]   cnt;
    logic               cell_s, cell_c;
    logic               last;
    logic [WIDTH-1:0]   b_load;
    logic               c_load;

`ifdef SOMADOR_SERIAL_SUB_EN
    // Subtraction is A + ~B + 1: invert B and force the initial carry.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    assign last = (cnt == CNT_W'(WIDTH - 1));

    celula_soma u_celula (
        .a    (reg_a[0]),
        .b    (reg_b[0]),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a  <= '0;
            reg_b  <= '0;
            psum   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    reg_a <= a;
                    reg_b <= b_load;
                    carry <= c_load;
                    cnt   <= '0;
                end
                SHIFT: begin
                    psum  <= {cell_s, psum[WIDTH-1:1]};
                    carry <= cell_c;
                    reg_a <= reg_a >> 1;
                    reg_b <= reg_b >> 1;
                    cnt   <= cnt + 1'b1;
                    // On the MSB cycle 'carry' is the carry into the MSB.
                    if (last) begin
                        sum_r  <= {cell_s, psum[WIDTH-1:1]};
                        cout_r <= cell_c;
                        ovf_r  <= carry ^ cell_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial: directed and random operations against an arithmetic model.
module tb_somador_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;
`ifdef SOMADOR_SERIAL_SUB_EN
    logic         sub = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout, exp_ovf;

    always #5 clk = ~clk;

    somador_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SOMADOR_SERIAL_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Model: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] full;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        s  = full[W-1:0];
        co = full[W];
        ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_sum"},  32'(sum),  32'(exp_sum));
        chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        chk({tag, "_ovf"},  32'(ovf),  32'(exp_ovf));
    endtask

    // Issue one operation and check timing and results. repulse >= 0 re-asserts start
    // (with garbage operands) at that SHIFT cycle; operands are scrambled while busy.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic [W-1:0] y_eff, input logic c_eff,
                          input int repulse);
        logic [W-1:0] ns;
        logic         nco, nov;
        @(negedge clk);
        start = 1'b1; a = x; b = y; cin = c;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            chk({tag, "_hold"}, 32'(sum), 32'(exp_sum));
            start = (i == repulse);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            if (i == repulse) a = '1;
            @(negedge clk);
            start = 1'b0;
        end
        model(x, y_eff, c_eff, ns, nco, nov);
        exp_sum = ns; exp_cout = nco; exp_ovf = nov;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        check_outputs(tag);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Idle with start low: nothing moves even with operands wiggling.
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            check_outputs("idle");
        end

        run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h01, 1'b0, -1);
        chk("add_0f_01_lit", 32'(sum), 32'h10);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h01, 1'b0, -1);
        chk("add_ff_01_cout", 32'(cout), 32'd1);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h01, 1'b0, -1);
        chk("add_7f_01_ovf", 32'(ovf), 32'd1);
        run_op("add_80_80", 8'h80, 8'h80, 1'b1, 8'h80, 1'b1, -1);

        // Start re-pulsed mid-operation must be ignored.
        run_op("repulse", 8'h10, 8'h20, 1'b1, 8'h20, 1'b1, 3);
        chk("repulse_lit", 32'(sum), 32'h31);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("repulse_no_2nd", 32'(busy), 32'd0);
        end

        // Reset in the middle of SHIFT discards the operation.
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        check_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            chk("midrst_nodone", 32'(done), 32'd0);
        end
        run_op("after_rst", 8'h02, 8'h03, 1'b0, 8'h03, 1'b0, -1);
        chk("after_rst_lit", 32'(sum), 32'h05);

        for (int n = 0; n < 20; n++) begin
            logic [W-1:0] x, y;
            logic         c;
            x = W'($urandom); y = W'($urandom); c = 1'($urandom);
            run_op("rand", x, y, c, y, c, -1);
        end

`ifdef SOMADOR_SERIAL_SUB_EN
        sub = 1'b1;
        run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 8'hF8, 1'b1, -1);
        chk("sub_05_07_lit", 32'(sum), 32'hFE);
        chk("sub_05_07_cout", 32'(cout), 32'd0);
        run_op("sub_07_05", 8'h07, 8'h05, 1'b0, 8'hFA, 1'b1, -1);
        chk("sub_07_05_lit", 32'(sum), 32'h02);
        chk("sub_07_05_cout", 32'(cout), 32'd1);
        sub = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
